// File: rtl/uart_rx_frame.sv
// UART receiver: 2-flop synchroniser, 3-sample majority vote per bit, configurable
// data/parity/stop format, and a show-ahead receive FIFO with per-entry error flags.

module uart_rx_frame #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        serial_in,
  output logic [DATA_BITS-1:0]        data_out,
  output logic                        data_out_perr,
  output logic                        data_out_ferr,
  output logic                        data_out_valid,
  input  logic                        data_out_ready,
  output logic                        overrun,
  input  logic                        clear_overrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CPB    = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF   = CPB / 2;
  localparam int CNT_W  = $clog2(CPB);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_FW = PTR_W + 1;
  localparam int ENT_W  = DATA_BITS + 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity_error(input logic [DATA_BITS-1:0] d, input logic p);
    logic x;
    x = (^d) ^ p;
    return (PARITY == 1) ? ~x : x;
  endfunction

  logic                 sync1_q, sync1_d, rxs_q, rxs_d, rxs_prev_q, rxs_prev_d;
  logic [1:0]           flush_q, flush_d;
  logic                 arm_q, arm_d;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic [PTR_W-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_FW-1:0]    count_q, count_d;
  logic                 overrun_q, overrun_d;
  logic [ENT_W-1:0]     mem_q [FIFO_DEPTH];

  logic bit_end, vote, vote_bit, last_stop;
  logic push, shift_en, par_en, ferr_clr, stop_vote;
  logic valid, full, pop, wr_en;
  logic [ENT_W-1:0] entry, head;

  // Input path; arm only after the synchroniser has flushed and seen an idle-high line
  always_comb begin
    sync1_d    = serial_in;
    rxs_d      = sync1_q;
    rxs_prev_d = rxs_q;
    flush_d    = {flush_q[0], 1'b1};
    arm_d      = arm_q | (flush_q[1] & rxs_q & rxs_prev_q);
  end

  assign bit_end   = (cnt_q == CNT_W'(CPB - 1));
  assign vote      = (cnt_q == CNT_W'(HALF + 1));
  assign vote_bit  = majority(samp_q[0], samp_q[1], rxs_q);
  assign last_stop = (stop_q == 1'(STOP_BITS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      flush_q    <= '0;
      arm_q      <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      rxs_q      <= rxs_d;
      rxs_prev_q <= rxs_prev_d;
      flush_q    <= flush_d;
      arm_q      <= arm_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    stop_d  = stop_q;
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        stop_d = 1'b0;
        if (arm_q && rxs_prev_q && !rxs_q) state_d = S_START;
      end
      S_START: begin
        if (vote && vote_bit) state_d = S_IDLE;
        else if (bit_end)     state_d = S_DATA;
      end
      S_DATA: begin
        if (vote) bit_d = bit_q + BIT_W'(1);
        if (bit_end && bit_q == BIT_W'(DATA_BITS))
          state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (vote && last_stop) state_d = S_IDLE;
        else if (bit_end)      stop_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    ferr_clr  = 1'b0;
    stop_vote = 1'b0;
    case (state_q)
      S_START:  ferr_clr = 1'b1;
      S_DATA:   shift_en = vote;
      S_PARITY: par_en   = vote;
      S_STOP: begin
        stop_vote = vote;
        push      = vote && last_stop;
      end
      default: ;
    endcase
  end

  // Frame datapath: vote samples, LSB-first shifter, error flags
  always_comb begin
    samp_d = samp_q;
    if (cnt_q == CNT_W'(HALF - 1)) samp_d[0] = rxs_q;
    if (cnt_q == CNT_W'(HALF))     samp_d[1] = rxs_q;
    shreg_d = shift_en ? {vote_bit, shreg_q[DATA_BITS-1:1]} : shreg_q;
    perr_d  = par_en ? parity_error(shreg_q, vote_bit) : perr_q;
    if (ferr_clr)                   ferr_d = 1'b0;
    else if (stop_vote && !vote_bit) ferr_d = 1'b1;
    else                            ferr_d = ferr_q;
    entry = {shreg_q, (PARITY != 0) & perr_q, ferr_q | ~vote_bit};
  end

  // FIFO control; a push while full is only accepted alongside a pop
  always_comb begin
    valid  = (count_q != '0);
    full   = (count_q == CNT_FW'(FIFO_DEPTH));
    pop    = valid && data_out_ready;
    wr_en  = push && (!full || pop);
    wptr_d = wptr_q + PTR_W'(wr_en);
    rptr_d = rptr_q + PTR_W'(pop);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_FW'(1);
      2'b01:   count_d = count_q - CNT_FW'(1);
      default: count_d = count_q;
    endcase
    if (push && full && !pop) overrun_d = 1'b1;
    else if (clear_overrun)   overrun_d = 1'b0;
    else                      overrun_d = overrun_q;
  end

  always_ff @(posedge clk) begin
    samp_q  <= samp_d;
    shreg_q <= shreg_d;
    perr_q  <= perr_d;
    ferr_q  <= ferr_d;
    if (wr_en) mem_q[wptr_q] <= entry;
  end

  assign head           = mem_q[rptr_q];
  assign data_out       = valid ? head[ENT_W-1:2] : '0;
  assign data_out_perr  = valid & head[1];
  assign data_out_ferr  = valid & head[0];
  assign data_out_valid = valid;
  assign overrun        = overrun_q;
  assign fifo_count     = count_q;

endmodule
